// File: rtl/mem_request_master.sv
// mem_request_master
//   Initiator side of the word-wide memory request/acknowledge interface.
//   Takes one read or write command at a time from a client, runs a
//   four-phase req/ack handshake toward the memory controller and returns
//   a one-cycle response pulse with read data and an error flag.
//
//   Build option: define MEM_REQ_TIMEOUT_EN to abort a request that has not
//   been acknowledged after TIMEOUT cycles (rsp_error=1). Without it the
//   request waits indefinitely and rsp_error is tied low.
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      asynchronous active-low reset
//   cmd_valid  client presents a command
//   cmd_ready  command can be accepted this cycle
//   cmd_write  1 = write, 0 = read
//   cmd_addr   word address
//   cmd_wdata  write data
//   rsp_valid  one-cycle completion pulse
//   rsp_rdata  read data (0 for writes and aborted transactions)
//   rsp_error  transaction aborted by timeout, valid with rsp_valid
//   mem_req    request to memory controller
//   mem_write  request type
//   mem_addr   request address
//   mem_wdata  request write data
//   mem_ack    controller acknowledge
//   mem_rdata  controller read data, valid while mem_ack is high on reads
//
// States
//   IDLE    | waiting for a command; ready when no stray ack is present
//   REQUEST | mem_req high, waiting for ack (or timeout)
//   RELEASE | mem_req low, waiting for the controller to drop ack
//   RESPOND | rsp_valid pulse for one cycle
module mem_request_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    RELEASE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   accept;
  logic   ack_take;

  // The timeout counter must be able to reach TIMEOUT.
  if (TIMEOUT >= (1 << TIMEOUT_W)) begin : g_bad_timeout
    $error("TIMEOUT does not fit in TIMEOUT_W bits");
  end

  // A stray ack left over from the controller blocks new requests so that
  // mem_req can never rise while mem_ack is high.
  assign cmd_ready = (state_q == IDLE) && !mem_ack;

`ifdef MEM_REQ_TIMEOUT_EN
  logic                 abort;
  logic [TIMEOUT_W-1:0] cnt_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    ack_take = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
    abort    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        // Ack has priority over a timeout landing in the same cycle.
        if (mem_ack) begin
          ack_take = 1'b1;
          state_d  = RELEASE;
        end
`ifdef MEM_REQ_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_W'(TIMEOUT)) begin
          abort   = 1'b1;
          state_d = RELEASE;
        end
`endif
      end
      RELEASE: begin
        if (!mem_ack) begin
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state_d == RESPOND);
      if (accept) begin
        mem_req   <= 1'b1;
        mem_write <= cmd_write;
        mem_addr  <= cmd_addr;
        mem_wdata <= cmd_wdata;
      end
      if (ack_take) begin
        mem_req   <= 1'b0;
        rsp_rdata <= mem_write ? '0 : mem_rdata;
      end
`ifdef MEM_REQ_TIMEOUT_EN
      if (abort) begin
        mem_req   <= 1'b0;
        rsp_rdata <= '0;
      end
`endif
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= '0;
      end else if ((state_q == REQUEST) && !mem_ack && !abort) begin
        cnt_q <= cnt_q + TIMEOUT_W'(1);
      end
      if (ack_take) begin
        rsp_error <= 1'b0;
      end else if (abort) begin
        rsp_error <= 1'b1;
      end
    end
  end
`else
  assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_request_master.sv
// Bench for mem_request_master: a transaction-level model predicts the
// handshake and response outputs every cycle; directed scenarios add
// literal checks on latency, data and ready behaviour.
module tb_mem_request_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          mem_req;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  mem_request_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one owed transaction at most. busy covers the
  // span from acceptance until the response is owed; acked marks that the
  // controller (or the timeout) has ended the request phase.
  bit          m_busy = 1'b0;
  bit          m_acked = 1'b0;
  bit          m_rsp = 1'b0;
  bit          m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  bit          m_err = 1'b0;
  int          m_wait = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0; m_acked = 1'b0; m_rsp = 1'b0; m_write = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0; m_wait = 0;
    end else if (m_rsp) begin
      m_rsp = 1'b0;
    end else if (!m_busy) begin
      if (cmd_valid && !mem_ack) begin
        m_busy = 1'b1; m_acked = 1'b0; m_wait = 0;
        m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
      end
    end else if (!m_acked) begin
      if (mem_ack) begin
        m_acked = 1'b1;
        m_rdata = m_write ? '0 : mem_rdata;
        m_err = 1'b0;
      end
`ifdef MEM_REQ_TIMEOUT_EN
      else if (m_wait == TO) begin
        m_acked = 1'b1;
        m_rdata = '0;
        m_err = 1'b1;
      end
`endif
      else m_wait++;
    end else if (!mem_ack) begin
      m_busy = 1'b0;
      m_rsp = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, !m_busy && !m_rsp && !mem_ack);
    chk("mem_req", mem_req, m_busy && !m_acked);
    chk("rsp_valid", rsp_valid, m_rsp);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("rsp_error", rsp_error, m_err);
    if (m_busy && !m_acked) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_write", mem_write, m_write);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
  end

  // Response monitor; rsp_edge is the clock edge that ends the pulse cycle.
  int            rsp_cnt = 0;
  int            rsp_edge = 0;
  logic [DW-1:0] rsp_data = '0;
  logic          rsp_err = 1'b0;
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_edge = cyc + 1;
      rsp_data = rsp_rdata;
      rsp_err = rsp_error;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, expected finish before time limit");
    $fatal(1);
  end

  int acc;
  int base;
  bit hold_ok;

  initial begin
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    reset = 1'b1;
    tick();

    // Read, ack two cycles after request.
    base = rsp_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_wdata = 32'h5555_5555;
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 32'h10);
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick(); tick();
    chk("t1_count", rsp_cnt - base, 1);
    chk("t1_latency", rsp_edge - acc, 5);
    chk("t1_rdata", rsp_data, 32'hDEAD_BEEF);
    chk("t1_error", rsp_err, 0);

    // Write, immediate ack; read data bus is ignored for writes.
    base = rsp_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h1234_5678;
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    chk("t2_req", mem_req, 1);
    chk("t2_wdata", mem_wdata, 32'h1234_5678);
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick(); tick();
    chk("t2_count", rsp_cnt - base, 1);
    chk("t2_latency", rsp_edge - acc, 3);
    chk("t2_rdata", rsp_data, 0);

    // Back-to-back with cmd_valid held and ack held four cycles.
    base = rsp_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
    tick();
    acc = cyc;
    cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'hA5A5_A5A5;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_ready_busy", cmd_ready, 0);
    end
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    chk("t3_ready_respond", cmd_ready, 0);
    chk("t3_no_req_respond", mem_req, 0);
    tick();
    chk("t3_no_req_idle", mem_req, 0);
    tick();
    chk("t3_second_req", mem_req, 1);
    chk("t3_second_addr", mem_addr, 32'h40);
    chk("t3_second_edge", cyc - acc, 7);
    cmd_valid = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick(); tick(); tick();
    chk("t3_count", rsp_cnt - base, 2);
    chk("t3_rdata", rsp_data, 0);

    // Unanswered request.
    base = rsp_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    tick();
    cmd_valid = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
    repeat (12) tick();
    chk("t4_count", rsp_cnt - base, 1);
    chk("t4_error", rsp_err, 1);
    chk("t4_rdata", rsp_data, 0);
    chk("t4_req_dropped", mem_req, 0);
    cmd_valid = 1'b1; cmd_addr = 32'h60;
    tick();
    cmd_valid = 1'b0;
    tick();
`else
    hold_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mem_req !== 1'b1) hold_ok = 1'b0;
    end
    chk("t4_req_held", hold_ok, 1);
    chk("t4_no_rsp", rsp_cnt - base, 0);
`endif

    // Reset in the middle of a request.
    base = rsp_cnt;
    chk("t5_req_before", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("t5_req_async_drop", mem_req, 0);
    chk("t5_ready_in_reset", cmd_ready, 1);
    tick();
    reset = 1'b1;
    tick();
    chk("t5_no_rsp", rsp_cnt - base, 0);
    chk("t5_ready_after", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4;
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0004;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick(); tick();
    chk("t5_count", rsp_cnt - base, 1);
    chk("t5_latency", rsp_edge - acc, 3);
    chk("t5_rdata", rsp_data, 32'hCAFE_0004);

    // Stray ack in IDLE blocks acceptance.
    base = rsp_cnt;
    mem_ack = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h70; cmd_wdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_ready_blocked", cmd_ready, 0);
      chk("t6_no_req", mem_req, 0);
    end
    mem_ack = 1'b0;
    tick();
    acc = cyc;
    chk("t6_accept", mem_req, 1);
    chk("t6_addr", mem_addr, 32'h70);
    cmd_valid = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick(); tick(); tick();
    chk("t6_count", rsp_cnt - base, 1);
    chk("t6_latency", rsp_edge - acc, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_request_master.md
Name: mem_request_master

Overview:
- Initiator side of the word-wide memory request/acknowledge interface that the memory controller serves.
- Accepts one read or write command at a time from a client (CPU core, DMA or test sequencer).
- Drives a four-phase req/ack handshake toward the memory controller and returns a one-cycle response carrying read data and an error flag.
- Sits between client FSMs and the memory controller; one outstanding transaction, no reordering.

Parameters:
- ADDR_W, 32, width of cmd_addr / mem_addr
- DATA_W, 32, width of all data buses
- TIMEOUT, 255, REQUEST-state cycles before abort (only with MEM_REQ_TIMEOUT_EN)
- TIMEOUT_W, 8, width of timeout counter; must satisfy TIMEOUT < 2^TIMEOUT_W

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  asynchronous, active-low reset (reset==0 resets)
- cmd_valid  input  1  client presents command
- cmd_ready  output  1  block can accept command this cycle
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_W  word address
- cmd_wdata  input  DATA_W  write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  DATA_W  read data (0 for writes / errors)
- rsp_error  output  1  transaction aborted by timeout; valid with rsp_valid
- mem_req  output  1  request to memory controller
- mem_write  output  1  request type
- mem_addr  output  ADDR_W  request address
- mem_wdata  output  DATA_W  request write data
- mem_ack  input  1  controller acknowledge; mem_rdata valid while high for reads
- mem_rdata  input  DATA_W  controller read data

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, timeout counter=0. cmd_ready is combinational and reads 1 after reset if mem_ack=0.
- States (2-bit encoding):
  - IDLE=0:
    - cmd_ready = (state==IDLE) && !mem_ack.
    - On cmd_valid && cmd_ready: register cmd_write/addr/wdata onto mem_write/mem_addr/mem_wdata, set mem_req=1, clear counter, go to REQUEST.
  - REQUEST=1:
    - mem_req held 1; mem_addr, mem_wdata and mem_write held stable.
    - mem_ack sampled 1: capture rsp_rdata = mem_write ? 0 : mem_rdata, rsp_error=0, mem_req=0, go to RELEASE.
    - Otherwise the counter increments.
  - RELEASE=2: wait for mem_ack==0, then go to RESPOND. If ack is already low, this takes one cycle.
  - RESPOND=3: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata and rsp_error hold until the next RESPOND.
- Latency: command accepted at edge N; mem_req high after N. With the controller acking in the first REQUEST cycle and dropping ack one cycle later, rsp_valid is high in cycle N+3. No back-pressure on the response; the client must take it.
- Handshake rules:
  - mem_req never rises while mem_ack is high.
  - mem_req never falls before ack is seen, except on timeout.
  - Address and data never change while mem_req=1.
- cmd inputs are ignored when cmd_ready=0. cmd_valid held across a busy period is accepted at the first ready cycle.
- Simultaneous events:
  - mem_ack arriving in the same cycle the counter hits TIMEOUT: ack wins, no error.
  - A new cmd_valid during RESPOND is not accepted until IDLE.
- Reset mid-transaction: mem_req drops immediately (async). The in-flight command is discarded with no rsp_valid.
- Stray mem_ack in IDLE (not owed): blocks cmd_ready until low; no other effect.

Optional Feature:
- Macro MEM_REQ_TIMEOUT_EN.
- Defined: in REQUEST, when counter == TIMEOUT and mem_ack==0, set mem_req=0, rsp_error=1, rsp_rdata=0, go to RELEASE, then RESPOND as normal.
- Undefined: the counter and error logic are absent, rsp_error is tied 0, and REQUEST waits indefinitely.

Test Plan:
- Read: cmd_write=0, addr=0x0000_0010; controller acks 2 cycles after req with mem_rdata=0xDEAD_BEEF -> one rsp_valid pulse, rsp_rdata=0xDEAD_BEEF, rsp_error=0; mem_addr stable at 0x10 throughout req.
- Write: cmd_write=1, addr=0x20, wdata=0x1234_5678; immediate ack -> mem_wdata=0x1234_5678 while req high; rsp_valid at accept+3, rsp_rdata=0.
- Back-to-back: cmd_valid held with two commands; controller holds ack 4 cycles -> second mem_req rises only after ack low and IDLE; cmd_ready=0 the whole time in between.
- Timeout (MEM_REQ_TIMEOUT_EN, TIMEOUT=4): no ack -> mem_req falls after 4 REQUEST cycles; rsp_valid with rsp_error=1, rsp_rdata=0. Same test without the macro -> mem_req stays high 100 cycles, no rsp_valid.
- Reset mid-REQUEST: drive reset=0 while mem_req=1 -> mem_req=0 in the same cycle, no rsp_valid; after release, cmd_ready=1 and a read of 0x4 completes normally.
- Stray ack: mem_ack=1 in IDLE for 3 cycles -> cmd_ready=0 for those cycles, no mem_req; the command is accepted the cycle after ack drops.
